mem_ctrl: RTL and testbench

- Memory/IO slave that sits directly downstream of the 8-bit cpu bus. It answers the cpu's read/write strobes with a one-cycle ready pulse.
- Holds a 254-byte RAM plus two memory-mapped IO bytes.
- Inserts a programmable number of wait states so the cpu's ready handshake is exercised.
- Single clock domain; the in_port input is the only asynchronous input.

---
 rtl/mem_ctrl.sv | 119 +++++++++++
 tb/tb_mem_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide memory/IO slave for the 8-bit cpu bus.
// Accepts one read or write strobe, inserts WAIT wait states, then answers
// with a single-cycle ready pulse. With IO_EN=1 the top two addresses map to
// a synchronised input port (0xFE) and an output register (0xFF).
module mem_ctrl #(
  parameter int WAIT  = 1,
  parameter bit IO_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       read,
  input  logic       write,
  output logic       ready,
  input  logic [7:0] in_port,
  output logic [7:0] out_port
);

  // The wait counter is 4 bits; anything outside 0..15 cannot be represented.
  if (WAIT < 0 || WAIT > 15) begin : g_wait_range
    $error("mem_ctrl: WAIT=%0d is outside the supported range 0..15", WAIT);
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK,
    RELEASE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        we_q;
  logic [7:0]  sync1, sync2;
  logic [7:0]  mem [0:255];
  logic [7:0]  read_mux;
  logic        accept;
  logic        commit;
  logic        is_io;

  // Exactly one strobe high is a legal request; both high is ignored.
  assign accept = (state == IDLE) && (read ^ write);
  assign commit = (state == BUSY) && (cnt == 4'd0);
  assign is_io  = IO_EN && (addr_q[7:1] == 7'h7F);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; ACK always lasts one cycle, RELEASE waits for both strobes low.
  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = ACK;
      ACK:     state_nxt = RELEASE;
      RELEASE: if (!read && !write) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data source for the latched address.
  always_comb begin
    read_mux = mem[addr_q];
    if (is_io) read_mux = addr_q[0] ? out_port : sync2;
  end

  // Request latch, wait counter, ready pulse, read data and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= 4'd0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      we_q     <= 1'b0;
      ready    <= 1'b0;
      rdata    <= 8'h00;
      out_port <= 8'h00;
    end else begin
      ready <= commit;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= wdata;
        we_q    <= write;
        cnt     <= 4'(WAIT);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !we_q) rdata <= read_mux;
      if (commit && we_q && is_io && addr_q[0]) out_port <= wdata_q;
    end
  end

  // Two-flop synchroniser for the asynchronous input port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // RAM write at the commit edge; an aborted request never reaches BUSY/commit.
  // NOTE: memory contents are deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    if (commit && we_q && !is_io) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: three instances cover WAIT=1/IO, WAIT=0/IO and
// WAIT=3/no-IO. Address, wdata and in_port are shared; strobes and resets are
// per instance so only the addressed instance ever sees a request.
module tb_mem_ctrl;

  logic       clk = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] in_port = 8'h00;
  logic       reset_n [3];
  logic       rd_req [3];
  logic       wr_req [3];
  logic       rdy [3];
  logic [7:0] rdata_o [3];
  logic [7:0] out_o [3];

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_cycles [3];

  always #5 clk = ~clk;

  mem_ctrl #(.WAIT(1), .IO_EN(1'b1)) u_w1 (
    .clk(clk), .reset(reset_n[0]), .address(address), .wdata(wdata),
    .rdata(rdata_o[0]), .read(rd_req[0]), .write(wr_req[0]), .ready(rdy[0]),
    .in_port(in_port), .out_port(out_o[0]));

  mem_ctrl #(.WAIT(0), .IO_EN(1'b1)) u_w0 (
    .clk(clk), .reset(reset_n[1]), .address(address), .wdata(wdata),
    .rdata(rdata_o[1]), .read(rd_req[1]), .write(wr_req[1]), .ready(rdy[1]),
    .in_port(in_port), .out_port(out_o[1]));

  mem_ctrl #(.WAIT(3), .IO_EN(1'b0)) u_w3 (
    .clk(clk), .reset(reset_n[2]), .address(address), .wdata(wdata),
    .rdata(rdata_o[2]), .read(rd_req[2]), .write(wr_req[2]), .ready(rdy[2]),
    .in_port(in_port), .out_port(out_o[2]));

  // Count clock cycles during which each ready output was high.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) if (rdy[i] === 1'b1) rdy_cycles[i]++;
  end

  // One complete transfer: lat = edges after acceptance until ready is seen,
  // width = cycles ready stays high; rd_at/out_at are sampled with ready high.
  task automatic xfer(input int i, input bit we, input logic [7:0] a,
                      input logic [7:0] d, output int lat, output int width,
                      output logic [7:0] rd_at, output logic [7:0] out_at);
    @(negedge clk);
    address = a; wdata = d; rd_req[i] = ~we; wr_req[i] = we;
    @(posedge clk);
    lat = 0; width = 0;
    while (lat < 40) begin
      @(posedge clk); #1; lat++;
      if (rdy[i] === 1'b1) break;
    end
    rd_at = rdata_o[i]; out_at = out_o[i];
    rd_req[i] = 1'b0; wr_req[i] = 1'b0;
    while (rdy[i] === 1'b1 && width < 8) begin
      width++; @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rdy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_ready[%0d] got %b want 0", i, rdy[i]); end
      n_cmp++; if (rdata_o[i] !== 8'h00) begin n_bad++; $display("FAIL reset_rdata[%0d] got %h want 00", i, rdata_o[i]); end
      n_cmp++; if (out_o[i] !== 8'h00) begin n_bad++; $display("FAIL reset_out[%0d] got %h want 00", i, out_o[i]); end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) reset_n[i] = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wait1;
    int lat, width, c0;
    logic [7:0] r, o;
    c0 = rdy_cycles[0];
    xfer(0, 1'b1, 8'h10, 8'h5A, lat, width, r, o);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL w1_write_lat got %0d want 2", lat); end
    n_cmp++; if (width !== 1) begin n_bad++; $display("FAIL w1_write_width got %0d want 1", width); end
    xfer(0, 1'b0, 8'h10, 8'h00, lat, width, r, o);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL w1_read_lat got %0d want 2", lat); end
    n_cmp++; if (width !== 1) begin n_bad++; $display("FAIL w1_read_width got %0d want 1", width); end
    n_cmp++; if (r !== 8'h5A) begin n_bad++; $display("FAIL w1_read_data got %h want 5a", r); end
    n_cmp++; if (rdy_cycles[0] - c0 !== 2) begin n_bad++; $display("FAIL w1_pulse_count got %0d want 2", rdy_cycles[0] - c0); end
  endtask

  task automatic test_held_strobe;
    int highs, first, lat, width;
    logic [7:0] r, o;
    highs = 0; first = 0;
    @(negedge clk);
    address = 8'h20; wdata = 8'h11; wr_req[1] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (rdy[1] === 1'b1) begin highs++; if (first == 0) first = n; end
    end
    wdata = 8'h22;
    repeat (3) begin @(posedge clk); #1; if (rdy[1] === 1'b1) highs++; end
    n_cmp++; if (first !== 1) begin n_bad++; $display("FAIL w0_held_first got %0d want 1", first); end
    n_cmp++; if (highs !== 1) begin n_bad++; $display("FAIL w0_held_pulses got %0d want 1", highs); end
    wr_req[1] = 1'b0;
    repeat (2) @(posedge clk);
    xfer(1, 1'b0, 8'h20, 8'h00, lat, width, r, o);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w0_read_lat got %0d want 1", lat); end
    n_cmp++; if (r !== 8'h11) begin n_bad++; $display("FAIL w0_read_data got %h want 11", r); end
  endtask

  task automatic test_io;
    int lat, width;
    logic [7:0] r, o;
    xfer(0, 1'b1, 8'hFF, 8'hC3, lat, width, r, o);
    n_cmp++; if (o !== 8'hC3) begin n_bad++; $display("FAIL io_out_at_ready got %h want c3", o); end
    in_port = 8'h7E;
    repeat (3) @(posedge clk);
    xfer(0, 1'b0, 8'hFE, 8'h00, lat, width, r, o);
    n_cmp++; if (r !== 8'h7E) begin n_bad++; $display("FAIL io_read_fe got %h want 7e", r); end
    xfer(0, 1'b0, 8'hFF, 8'h00, lat, width, r, o);
    n_cmp++; if (r !== 8'hC3) begin n_bad++; $display("FAIL io_read_ff got %h want c3", r); end
    xfer(0, 1'b0, 8'hFE, 8'h00, lat, width, r, o);
    xfer(0, 1'b1, 8'hFE, 8'h99, lat, width, r, o);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL io_wr_fe_lat got %0d want 2", lat); end
    n_cmp++; if (rdata_o[0] !== 8'h7E) begin n_bad++; $display("FAIL io_wr_fe_rdata got %h want 7e", rdata_o[0]); end
    n_cmp++; if (out_o[0] !== 8'hC3) begin n_bad++; $display("FAIL io_wr_fe_out got %h want c3", out_o[0]); end
  endtask

  task automatic test_illegal;
    int highs, lat;
    highs = 0;
    @(negedge clk);
    address = 8'h10; wdata = 8'hEE; rd_req[0] = 1'b1; wr_req[0] = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (rdy[0] === 1'b1) highs++; end
    n_cmp++; if (highs !== 0) begin n_bad++; $display("FAIL illegal_ready got %0d pulses want 0", highs); end
    wr_req[0] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1; lat++;
      if (rdy[0] === 1'b1) break;
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL illegal_then_read_lat got %0d want 3", lat); end
    n_cmp++; if (rdata_o[0] !== 8'h5A) begin n_bad++; $display("FAIL illegal_ram_kept got %h want 5a", rdata_o[0]); end
    rd_req[0] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_abort;
    int lat, width;
    logic [7:0] r, o;
    xfer(2, 1'b1, 8'h30, 8'h00, lat, width, r, o);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL w3_write_lat got %0d want 4", lat); end
    @(negedge clk);
    address = 8'h30; wdata = 8'hAA; wr_req[2] = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    reset_n[2] = 1'b0;
    #1;
    n_cmp++; if (rdy[2] !== 1'b0) begin n_bad++; $display("FAIL abort_ready got %b want 0", rdy[2]); end
    wr_req[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n[2] = 1'b1;
    repeat (2) @(posedge clk);
    xfer(2, 1'b0, 8'h30, 8'h00, lat, width, r, o);
    n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL abort_ram_kept got %h want 00", r); end
  endtask

  task automatic test_no_io;
    int lat, width;
    logic [7:0] r, o;
    xfer(2, 1'b1, 8'hFF, 8'h44, lat, width, r, o);
    n_cmp++; if (o !== 8'h00) begin n_bad++; $display("FAIL noio_out got %h want 00", o); end
    xfer(2, 1'b0, 8'hFF, 8'h00, lat, width, r, o);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL noio_read_lat got %0d want 4", lat); end
    n_cmp++; if (r !== 8'h44) begin n_bad++; $display("FAIL noio_read_ff got %h want 44", r); end
    n_cmp++; if (out_o[2] !== 8'h00) begin n_bad++; $display("FAIL noio_out_after got %h want 00", out_o[2]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset_n[i] = 1'b0; rd_req[i] = 1'b0; wr_req[i] = 1'b0; rdy_cycles[i] = 0;
    end
    test_reset;
    test_wait1;
    test_held_strobe;
    test_io;
    test_illegal;
    test_reset_abort;
    test_no_io;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule
